// File: rtl/bmi_bitscan_seq_pkg.sv
// Shared definitions for the bit-manipulation ALU PEXT/PDEP sequencer.
package bmi_bitscan_seq_pkg;

  localparam logic OP_PEXT = 1'b0;
  localparam logic OP_PDEP = 1'b1;

  // Destination index width carried in a tag; matches the 16:1 mux select width.
  localparam int TAG_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A tag follows each mux request down the mux pipeline. It says whether the
  // returning bit must be stored and at which result position.
  typedef struct packed {
    logic                 valid;
    logic [TAG_SEL_W-1:0] dest;
  } tag_t;

endpackage

// File: rtl/bmi_tag_pipe.sv
// Tag delay line that keeps write-back tags aligned with the bit mux latency.
module bmi_tag_pipe #(
  parameter int MUX_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag
);

  generate
    if (MUX_LAT == 0) begin : g_bypass
      // Combinational mux: the tag is consumed in the cycle it is issued.
      assign o_tag = i_tag;
    end else begin : g_pipe
      logic [TAG_W-1:0] r_stage [MUX_LAT];

      // Shift one stage per cycle; the mux pipeline never stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < MUX_LAT; j++) r_stage[j] <= '0;
        end else begin
          r_stage[0] <= i_tag;
          for (int j = 1; j < MUX_LAT; j++) r_stage[j] <= r_stage[j-1];
        end
      end

      assign o_tag = r_stage[MUX_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/bmi_bitscan_seq.sv
// PEXT/PDEP sequencer: walks the mask one bit per cycle, drives the external
// 16:1 bit mux and packs the returning bits into the result word.
module bmi_bitscan_seq
  import bmi_bitscan_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int MUX_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_op,
  input  logic [DATA_WIDTH-1:0] in_src,
  input  logic [DATA_WIDTH-1:0] in_mask,
  output logic [DATA_WIDTH-1:0] mux_data,
  output logic [SEL_WIDTH-1:0]  mux_sel,
  input  logic                  mux_bit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [SEL_WIDTH:0]    out_cnt
);

  localparam int DRAIN_W = (MUX_LAT < 2) ? 1 : $clog2(MUX_LAT + 1);
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'((MUX_LAT > 0) ? MUX_LAT - 1 : 0);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX   = SEL_WIDTH'(DATA_WIDTH - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_src;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_result;
  logic [SEL_WIDTH-1:0]  r_idx;
  logic [SEL_WIDTH:0]    r_k;
  logic [SEL_WIDTH-1:0]  r_sel_hold;
  logic [DRAIN_W-1:0]    r_drain;
  logic                  w_accept;
  logic [SEL_WIDTH-1:0]  w_sel;
  tag_t                  w_tag_in;
  tag_t                  w_tag_out;

  assign w_accept = in_valid && (r_state == IDLE);

  // PEXT reads source bit i; PDEP reads the next unconsumed source bit k.
  assign w_sel = (r_op == OP_PEXT) ? r_idx : r_k[SEL_WIDTH-1:0];

  assign w_tag_in.valid = (r_state == SCAN) && r_mask[r_idx];
  assign w_tag_in.dest  = (r_op == OP_PEXT) ? r_k[SEL_WIDTH-1:0] : r_idx;

  bmi_tag_pipe #(
    .MUX_LAT (MUX_LAT),
    .TAG_W   ($bits(tag_t))
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: fixed-length scan, optional drain for in-flight mux bits.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = SCAN;
      SCAN:    if (r_idx == LAST_IDX) w_state_nxt = (MUX_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (r_drain == DRAIN_LAST) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Operand capture, scan counters and bit write-back from returning tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_PEXT;
      r_src      <= '0;
      r_mask     <= '0;
      r_result   <= '0;
      r_idx      <= '0;
      r_k        <= '0;
      r_sel_hold <= '0;
      r_drain    <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= in_op;
        r_src    <= in_src;
        r_mask   <= in_mask;
        r_result <= '0;
        r_idx    <= '0;
        r_k      <= '0;
      end else begin
        if (r_state == SCAN) begin
          r_idx      <= r_idx + 1'b1;
          r_sel_hold <= w_sel;
          if (w_tag_in.valid) r_k <= r_k + 1'b1;
        end
        if (w_tag_out.valid) r_result[w_tag_out.dest] <= mux_bit;
      end
      r_drain <= (r_state == DRAIN) ? r_drain + 1'b1 : '0;
    end
  end

  assign mux_data   = r_src;
  assign mux_sel    = (r_state == SCAN) ? w_sel : r_sel_hold;
  assign out_result = r_result;
  assign out_cnt    = r_k;

endmodule

// File: doc/bmi_bitscan_seq.md
Name: bmi_bitscan_seq

Overview:
- Sequencer for bit-extract (PEXT) and bit-deposit (PDEP) ops in the bit-manipulation ALU.
- Sits on both sides of the 16:1 bit mux:
  - drives the mux data word and select lines, one index per cycle;
  - consumes the mux's 1-bit output and packs each bit into the result word.
- Accepts one operation at a time through a valid/ready handshake and returns the result through a second valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, operand/result width; equals the mux input width.
- SEL_WIDTH, 4, mux select width; log2(DATA_WIDTH).
- MUX_LAT, 2, cycles from mux_sel/mux_data presented to mux_bit valid; 0 means the mux is combinational.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE.
- in_op  input  1  0 = PEXT, 1 = PDEP.
- in_src  input  DATA_WIDTH  source operand.
- in_mask  input  DATA_WIDTH  bit mask.
- mux_data  output  DATA_WIDTH  to mux A_in; held at the captured src for the whole op.
- mux_sel  output  SEL_WIDTH  to mux sel.
- mux_bit  input  1  from mux out.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  DATA_WIDTH  packed result.
- out_cnt  output  SEL_WIDTH+1  popcount of mask; number of bits moved.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - out_result, out_cnt, mux_data and mux_sel = 0.
  - Tag pipe cleared; all counters = 0.
- States: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - in_valid & in_ready at edge T captures op, src and mask.
  - Clears result and k; moves to SCAN.
- SCAN, 16 cycles (T+1 .. T+16), scan index i = 0..15, one per cycle:
  - PEXT: mux_sel = i. If mask[i], issue tag {valid=1, dest=k} and increment k.
  - PDEP: mux_sel = k. If mask[i], issue tag {valid=1, dest=i} and increment k.
  - If mask[i] = 0: issue tag valid=0 and hold k.
  - In PDEP, k never exceeds 15 because k <= i; no wrap.
  - After i = 15, go to DRAIN.
- Tag pipe:
  - MUX_LAT-deep shift register aligned to the mux latency.
  - When a valid tag exits, result[dest] <= mux_bit in that cycle.
  - With MUX_LAT = 0, the write happens in the same cycle as the issue.
- DRAIN:
  - Lasts MUX_LAT cycles; mux_sel holds its last value.
  - With MUX_LAT = 0, DRAIN is skipped.
  - Then go to DONE.
- DONE:
  - out_valid = 1 from cycle T+17+MUX_LAT.
  - out_result and out_cnt (= k) stay stable while out_valid & !out_ready.
  - On out_valid & out_ready: return to IDLE with out_valid = 0 next cycle. in_ready is 1 that cycle; no same-cycle accept in DONE.
- Fixed latency of 17 + MUX_LAT cycles, regardless of mask. mask = 0 gives result 0 and cnt 0 at the same latency.
- mask = 0xFFFF:
  - PEXT and PDEP both return src; cnt = 16, which needs the SEL_WIDTH+1 width.
- Result bits not written stay 0.
- in_valid while busy is ignored, because in_ready = 0; inputs may change freely.
- rst_n low mid-SCAN or mid-DRAIN aborts immediately, returning all outputs to their reset values. No partial result is emitted.

Decomposition:
- Shared ALU package holds:
  - OP_PEXT = 1'b0 and OP_PDEP = 1'b1;
  - the state enum {IDLE, SCAN, DRAIN, DONE};
  - the tag struct {valid, dest[SEL_WIDTH-1:0]}.
- One sub-module: bmi_tag_pipe.
  - Parameterised MUX_LAT-deep tag delay line with async active-low clear.
  - Generate-bypass when MUX_LAT = 0.

Test Plan:
- PEXT src=0xA5C3 mask=0x00FF -> out_result=0x00C3, out_cnt=8, out_valid first high at T+19 (MUX_LAT=2).
- PEXT src=0xF0F0 mask=0xAAAA -> out_result=0x00CC, out_cnt=8.
- PDEP src=0x0035 mask=0x0F0F -> out_result=0x0305, out_cnt=8. PDEP src=0x1234 mask=0xFFFF -> 0x1234, out_cnt=16.
- mask=0x0000 (either op) -> out_result=0x0000, out_cnt=0, same latency. mask=0x8000 PEXT src=0x8000 -> 0x0001, cnt=1.
- Backpressure: out_ready held low 5 cycles after out_valid:
  - result stays stable, in_ready stays 0, and a second in_valid pulse is ignored;
  - after the handshake the next op is accepted and its result is correct.
- rst_n pulsed low at T+8 of a PEXT:
  - all outputs go to their reset values asynchronously; no out_valid is seen;
  - a following op src=0xFFFF mask=0x0F00 -> 0x000F, cnt=4.
- Rerun all of the above with MUX_LAT=0: latency T+17.
